conv3x3_win_mac8: RTL and testbench
===================================

Name: conv3x3_win_mac8

Overview:
- Consumer stage directly downstream of the 8-channel 3x3 line-buffer collector.
- Tracks the pixel position of the stream feeding the line buffers and decides which 3x3 windows are complete (valid convolution, no padding).
- Multiplies each complete window's 8 channels x 9 unsigned int4 activations by a latched bank of signed int4 weights and reduces the 72 products through a 3-stage pipeline to one 16-bit signed partial sum per output pixel.

Parameters:
LEN1, 16, row width for sel=0
LEN2, 14, row width for sel=1
LEN3, 28, row width for sel=2
LEN4, 56, row width for sel=3
LEN5, 112, row width for sel=4
LEN6, 224, row width for sel=5
WIN_LAT, 1, cycles from pixel_valid to the matching window at ifm_win3x3_*; range 0..3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sel  in  3  feature-map size select; sampled only with frame_start
frame_start  in  1  qualifies the current pixel_valid pixel as (row 0, col 0)
pixel_valid  in  1  one pixel entered the line buffers this cycle
ifm_win3x3_0..ifm_win3x3_7  in  36 each  per-channel window; element k at [4k+3:4k], k=0..8 row-major, k=0 top-left, k=8 newest; unsigned 0..15
wgt_in  in  288  channel ch at [36ch+35:36ch], same element order; signed int4
wgt_load  in  1  latch wgt_in
out_valid  out  1  out_data valid
out_data  out  16  signed partial sum
out_last  out  1  with out_valid, last window of the frame
busy  out  1  frame in progress or pipeline non-empty

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, busy=0; row, col, width and weight registers cleared; pipeline valids cleared.
- Width latch: on pixel_valid&&frame_start, W = LEN[sel+1] for sel 0..5. For sel 6/7, W=0: the frame is ignored, no outputs, and counters stay idle until the next frame_start.
- Position counters (8-bit row/col), advance only on pixel_valid:
  - frame_start forces the pixel to (0,0); next position is (0,1).
  - col wraps W-1 -> 0 and increments row.
  - At (W-1,W-1): frame ends; counters go idle, and further pixel_valid without frame_start is ignored.
  - frame_start mid-frame aborts the current frame and restarts at (0,0); windows already in the pipeline still drain.
- Window complete when the pixel at (r,c) has r>=2 and c>=2. Exactly (W-2)^2 outputs per frame, e.g. 196 for W=16.
- Window-valid flag and last flag are delayed WIN_LAT cycles before sampling ifm_win3x3_*.
- Pipeline, one window per cycle sustained with no stalls:
  - S1: 72 products, zero-extended activation x signed weight, 9-bit signed, range -120..105.
  - S2: per-channel 9-term sum, 12-bit signed.
  - S3: 8-channel sum, 15-bit signed, sign-extended to 16 bits into out_data.
- Latency: out_valid is asserted WIN_LAT+3 cycles after the pixel_valid cycle of the completing pixel.
- out_valid is a single-cycle pulse per window. out_data holds its value when out_valid=0.
- out_last is asserted with out_valid for pixel (W-1,W-1) only.
- wgt_load: weights latch at the edge. Windows entering S1 on the following cycle or later use the new weights; in-flight windows keep the old ones. wgt_load in the same cycle as an S1 entry: that window uses the old weights.
- busy = counters active OR any pipeline/delay stage valid.

Optional Feature:
- Macro RELU_EN.
- Defined: S3 result clamped to 0 if negative; out_data is never negative.
- Undefined: raw signed sum is output.
- Latency is identical either way.

Test Plan:
- sel=0, all activations 15, all weights 7, 256 contiguous pixels with frame_start on the first -> 196 outputs, each 7560; out_last only on the 196th; first out_valid 4 cycles after pixel (2,2).
- All activations 15, all weights -8 -> out_data=-8640 (0xDE40); with RELU_EN -> 0.
- Channel 3 element 4 weight=1, all other weights 0; activation ramp (r*W+c)&15 -> out_data equals the centre pixel (r-1,c-1)&15 per window.
- Gapped pixel_valid (every other cycle), sel=1 -> 144 outputs, same values as contiguous; busy drops 4 cycles after the last output input.
- wgt_load from all-1 to all-2 weights mid-frame, all activations 1 -> outputs step 72 -> 144 with no mixed value; frame_start at (5,3) restarts counting with 0 outputs until new (2,2); sel=7 frame -> no outputs.
- rst_n asserted mid-frame -> all outputs 0 immediately; next frame behaves as fresh.

Source files
------------

// File: rtl/conv3x3_win_mac8.sv
// 3x3 window tracker and 8-channel int4 MAC: 72 products reduced to one 16-bit partial sum per window.
// Optional macro RELU_EN clamps negative sums to zero; default build outputs the raw signed sum.
module conv3x3_win_mac8 #(
  parameter int unsigned LEN1    = 16,
  parameter int unsigned LEN2    = 14,
  parameter int unsigned LEN3    = 28,
  parameter int unsigned LEN4    = 56,
  parameter int unsigned LEN5    = 112,
  parameter int unsigned LEN6    = 224,
  parameter int unsigned WIN_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   sel,
  input  logic         frame_start,
  input  logic         pixel_valid,
  input  logic [35:0]  ifm_win3x3_0,
  input  logic [35:0]  ifm_win3x3_1,
  input  logic [35:0]  ifm_win3x3_2,
  input  logic [35:0]  ifm_win3x3_3,
  input  logic [35:0]  ifm_win3x3_4,
  input  logic [35:0]  ifm_win3x3_5,
  input  logic [35:0]  ifm_win3x3_6,
  input  logic [35:0]  ifm_win3x3_7,
  input  logic [287:0] wgt_in,
  input  logic         wgt_load,
  output logic         out_valid,
  output logic [15:0]  out_data,
  output logic         out_last,
  output logic         busy
);

  logic [7:0]  w_len;
  logic [7:0]  w_width, w_row, w_col;
  logic        w_accept, w_col_end, w_frame_end;
  logic        w_win_v, w_win_last;
  logic        w_s0_v, w_s0_last, w_dly_any;
  logic [35:0] w_act [8];

  logic [7:0]   r_row, r_col, r_width;
  logic         r_active;
  logic [287:0] r_wgt;

  logic              r_s1_v, r_s1_last;
  logic signed [8:0] r_s1_prod [8][9];
  logic signed [8:0] w_prod    [8][9];
  logic              r_s2_v, r_s2_last;
  logic [11:0]       r_s2_sum [8];
  logic [11:0]       w_ch_sum [8];
  logic [14:0]       w_sum, w_res;
  logic              r_out_valid, r_out_last;
  logic [15:0]       r_out_data;

  always_comb begin
    w_len = 8'd0;
    case (sel)
      3'd0:    w_len = 8'(LEN1);
      3'd1:    w_len = 8'(LEN2);
      3'd2:    w_len = 8'(LEN3);
      3'd3:    w_len = 8'(LEN4);
      3'd4:    w_len = 8'(LEN5);
      3'd5:    w_len = 8'(LEN6);
      default: w_len = 8'd0;
    endcase
  end

  // frame_start overrides the tracked position and width for the current pixel
  assign w_width     = frame_start ? w_len : r_width;
  assign w_row       = frame_start ? 8'd0 : r_row;
  assign w_col       = frame_start ? 8'd0 : r_col;
  assign w_accept    = pixel_valid && (frame_start ? (w_len != 8'd0) : r_active);
  assign w_col_end   = (w_col == w_width - 8'd1);
  assign w_frame_end = w_col_end && (w_row == w_width - 8'd1);
  assign w_win_v     = w_accept && (w_row >= 8'd2) && (w_col >= 8'd2);
  assign w_win_last  = w_win_v && w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_row    <= 8'd0;
      r_col    <= 8'd0;
      r_width  <= 8'd0;
    end else if (pixel_valid && frame_start && (w_len == 8'd0)) begin
      r_active <= 1'b0;
      r_row    <= 8'd0;
      r_col    <= 8'd0;
      r_width  <= 8'd0;
    end else if (w_accept) begin
      r_width <= w_width;
      if (w_frame_end) begin
        r_active <= 1'b0;
        r_row    <= 8'd0;
        r_col    <= 8'd0;
      end else begin
        r_active <= 1'b1;
        if (w_col_end) begin
          r_col <= 8'd0;
          r_row <= w_row + 8'd1;
        end else begin
          r_col <= w_col + 8'd1;
          r_row <= w_row;
        end
      end
    end
  end

  generate
    if (WIN_LAT == 0) begin : g_nodly
      assign w_s0_v    = w_win_v;
      assign w_s0_last = w_win_last;
      assign w_dly_any = 1'b0;
    end else begin : g_dly
      logic [WIN_LAT-1:0] r_dly_v, r_dly_last;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dly_v    <= '0;
          r_dly_last <= '0;
        end else begin
          r_dly_v[0]    <= w_win_v;
          r_dly_last[0] <= w_win_last;
          for (int i = 1; i < int'(WIN_LAT); i++) begin
            r_dly_v[i]    <= r_dly_v[i-1];
            r_dly_last[i] <= r_dly_last[i-1];
          end
        end
      end
      assign w_s0_v    = r_dly_v[WIN_LAT-1];
      assign w_s0_last = r_dly_last[WIN_LAT-1];
      assign w_dly_any = |r_dly_v;
    end
  endgenerate

  assign w_act[0] = ifm_win3x3_0;
  assign w_act[1] = ifm_win3x3_1;
  assign w_act[2] = ifm_win3x3_2;
  assign w_act[3] = ifm_win3x3_3;
  assign w_act[4] = ifm_win3x3_4;
  assign w_act[5] = ifm_win3x3_5;
  assign w_act[6] = ifm_win3x3_6;
  assign w_act[7] = ifm_win3x3_7;

  // Weights update on the same edge that S1 samples, so that window sees the old bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wgt <= '0;
    end else if (wgt_load) begin
      r_wgt <= wgt_in;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 9; k++) begin
        w_prod[ch][k] = $signed({5'b0, w_act[ch][4*k +: 4]}) *
                        $signed({{5{r_wgt[36*ch+4*k+3]}}, r_wgt[36*ch+4*k +: 4]});
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < 8; ch++) begin
      w_ch_sum[ch] = 12'd0;
      for (int k = 0; k < 9; k++) begin
        w_ch_sum[ch] = w_ch_sum[ch] + {{3{r_s1_prod[ch][k][8]}}, r_s1_prod[ch][k]};
      end
    end
  end

  always_comb begin
    w_sum = 15'd0;
    for (int ch = 0; ch < 8; ch++) begin
      w_sum = w_sum + {{3{r_s2_sum[ch][11]}}, r_s2_sum[ch]};
    end
  end

`ifdef RELU_EN
  assign w_res = w_sum[14] ? 15'd0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s2_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= 16'd0;
      for (int ch = 0; ch < 8; ch++) begin
        r_s2_sum[ch] <= 12'd0;
        for (int k = 0; k < 9; k++) r_s1_prod[ch][k] <= 9'sd0;
      end
    end else begin
      r_s1_v      <= w_s0_v;
      r_s1_last   <= w_s0_last;
      r_s2_v      <= r_s1_v;
      r_s2_last   <= r_s1_last;
      r_out_valid <= r_s2_v;
      r_out_last  <= r_s2_v && r_s2_last;
      if (w_s0_v) begin
        for (int ch = 0; ch < 8; ch++) begin
          for (int k = 0; k < 9; k++) r_s1_prod[ch][k] <= w_prod[ch][k];
        end
      end
      if (r_s1_v) begin
        for (int ch = 0; ch < 8; ch++) r_s2_sum[ch] <= w_ch_sum[ch];
      end
      if (r_s2_v) r_out_data <= {w_res[14], w_res};
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_active || w_dly_any || r_s1_v || r_s2_v;

endmodule

// File: tb/tb_conv3x3_win_mac8.sv
// Directed bench for conv3x3_win_mac8: table of uniform frames plus ramp, weight-swap,
// abort, ignored-pixel and reset sequences. Inputs driven and outputs sampled on negedge.
module tb_conv3x3_win_mac8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   sel;
  logic         frame_start, pixel_valid, wgt_load;
  logic [35:0]  ifm [8];
  logic [287:0] wgt_in;
  logic         out_valid, out_last, busy;
  logic [15:0]  out_data;

  typedef struct {int data; logic last;} exp_t;
  typedef struct {int s; logic [3:0] act; int w; int gap; int exp_cnt; int exp_val;} vec_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, n_out = 0, first_out_cyc = -1, p22_cyc = 0, hold_data = 0;
  int g_mode = 0, g_w = 16, prev_r = 0, prev_c = 0;
  logic [3:0]   g_act = 4'd0;
  logic [287:0] g_wgt_new = '0;
  logic         prev_have = 1'b0;

`ifdef RELU_EN
  localparam int ExpNeg8640 = 0;
  localparam int ExpNeg432  = 0;
`else
  localparam int ExpNeg8640 = -8640;
  localparam int ExpNeg432  = -432;
`endif

  conv3x3_win_mac8 dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .ifm_win3x3_0(ifm[0]), .ifm_win3x3_1(ifm[1]), .ifm_win3x3_2(ifm[2]), .ifm_win3x3_3(ifm[3]),
    .ifm_win3x3_4(ifm[4]), .ifm_win3x3_5(ifm[5]), .ifm_win3x3_6(ifm[6]), .ifm_win3x3_7(ifm[7]),
    .wgt_in(wgt_in), .wgt_load(wgt_load), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Output monitor: every pulse is matched against the expected queue in order
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_data = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("extra_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", int'($signed(out_data)), e.data);
        check("out_last", int'(out_last), int'(e.last));
      end
      hold_data = int'($signed(out_data));
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end else begin
      check("hold_idle", int'($signed(out_data)) + (out_last ? 100000 : 0), hold_data);
    end
  end

  function automatic int wtab(input int s);
    case (s)
      0: return 16;
      1: return 14;
      2: return 28;
      3: return 56;
      4: return 112;
      5: return 224;
      default: return 0;
    endcase
  endfunction

  function automatic logic [287:0] fill4(input int w);
    logic [287:0] p;
    for (int i = 0; i < 72; i++) p[4*i +: 4] = 4'(w);
    return p;
  endfunction

  // Window whose newest element is pixel (r,c); ramp mode offsets each channel by ch
  function automatic logic [35:0] win(input int r, input int c, input int ch);
    logic [35:0] v;
    int p;
    for (int k = 0; k < 9; k++) begin
      if (g_mode == 0) begin
        v[4*k +: 4] = g_act;
      end else begin
        p = (r - 2 + k / 3) * g_w + (c - 2 + k % 3) + ch;
        v[4*k +: 4] = 4'(p & 15);
      end
    end
    return v;
  endfunction

  task automatic tick(input logic pv, input logic fs, input int s, input logic ld,
                      input int r, input int c);
    @(negedge clk);
    if (prev_have || g_mode == 0) begin
      for (int ch = 0; ch < 8; ch++) ifm[ch] = win(prev_r, prev_c, ch);
    end
    prev_have   = pv;
    prev_r      = r;
    prev_c      = c;
    pixel_valid = pv;
    frame_start = fs;
    sel         = 3'(s);
    wgt_load    = ld;
    if (ld) wgt_in = g_wgt_new;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic set_wgt(input logic [287:0] p);
    g_wgt_new = p;
    tick(1'b0, 1'b0, 0, 1'b1, 0, 0);
    idle();
  endtask

  task automatic drive_frame(input int s, input int gap, input int npix, input int exp_lo,
                             input int exp_hi, input int load_idx);
    int w, n, r, c, val;
    w   = wtab(s);
    g_w = (w == 0) ? 16 : w;
    n   = (w == 0) ? 64 : w * w;
    if (npix >= 0) n = npix;
    for (int i = 0; i < n; i++) begin
      r = (w == 0) ? 0 : i / w;
      c = (w == 0) ? 0 : i % w;
      if (i > 0) for (int g = 0; g < gap; g++) idle();
      tick(1'b1, i == 0, s, i == load_idx, r, c);
      if (w > 0 && r >= 2 && c >= 2) begin
        if (g_mode == 1) val = ((r - 1) * w + (c - 1) + 3) & 15;
        else val = (load_idx >= 0 && i >= load_idx) ? exp_hi : exp_lo;
        q.push_back('{val, (r == w - 1 && c == w - 1)});
        if (r == 2 && c == 2) p22_cyc = cyc;
      end
    end
  endtask

  task automatic tail_checks(input int w);
    for (int i = 1; i <= 4; i++) begin
      idle();
      if (w > 0 && i == 3) check("busy_tail_hi", int'(busy), 1);
      if (w > 0 && i == 4) check("busy_tail_lo", int'(busy), 0);
      if (w == 0 && i == 1) check("busy_ignored", int'(busy), 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 40) begin
      idle();
      t++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (6) idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    logic [287:0] p;
    int base;

    vt[0] = '{0, 4'd15,  7, 0, 196, 7560};
    vt[1] = '{0, 4'd15, -8, 0, 196, ExpNeg8640};
    vt[2] = '{1, 4'd15,  7, 1, 144, 7560};
    vt[3] = '{2, 4'd3,  -2, 0, 676, ExpNeg432};
    vt[4] = '{7, 4'd15,  7, 0,   0, 0};
    vt[5] = '{1, 4'd0,   5, 0, 144, 0};

    rst_n = 1'b0; sel = 3'd0; frame_start = 1'b0; pixel_valid = 1'b0; wgt_load = 1'b0;
    wgt_in = '0;
    for (int ch = 0; ch < 8; ch++) ifm[ch] = '0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      g_mode = 0;
      g_act  = vt[v].act;
      set_wgt(fill4(vt[v].w));
      base = n_out;
      first_out_cyc = -1;
      drive_frame(vt[v].s, vt[v].gap, -1, vt[v].exp_val, 0, -1);
      tail_checks(wtab(vt[v].s));
      drain();
      check("frame_count", n_out - base, vt[v].exp_cnt);
      if (vt[v].exp_cnt > 0) check("latency", first_out_cyc - p22_cyc, 4);
    end

    // Pixels after the frame has ended are ignored
    base = n_out;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 0, 1'b0, 0, 0);
    check("post_frame_busy", int'(busy), 0);
    drain();
    check("post_frame_count", n_out - base, 0);

    // Single tap on channel 3 centre picks out the centre pixel of each window
    g_mode = 1;
    p = '0;
    p[127:124] = 4'd1;
    set_wgt(p);
    base = n_out;
    drive_frame(1, 0, -1, 0, 0, -1);
    tail_checks(14);
    drain();
    check("ramp_count", n_out - base, 144);

    // Weight swap mid-frame: window entering S1 on the load edge keeps the old bank
    g_mode = 0;
    g_act  = 4'd1;
    set_wgt(fill4(1));
    g_wgt_new = fill4(2);
    base = n_out;
    drive_frame(0, 0, -1, 72, 144, 100);
    drain();
    check("wload_count", n_out - base, 196);

    // Abort at (5,3): 43 windows from the aborted frame then a full fresh frame
    g_act = 4'd15;
    set_wgt(fill4(7));
    base = n_out;
    drive_frame(0, 0, 83, 7560, 0, -1);
    drive_frame(0, 0, -1, 7560, 0, -1);
    drain();
    check("abort_count", n_out - base, 239);

    // Reset mid-frame: outputs clear at once, weights clear, next frame is fresh
    drive_frame(0, 0, 120, 7560, 0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    check("mid_rst_busy", int'(busy), 0);
    q.delete();
    prev_have = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_out;
    drive_frame(1, 0, -1, 0, 0, -1);
    tail_checks(14);
    drain();
    check("post_rst_zero_wgt_count", n_out - base, 144);
    set_wgt(fill4(7));
    base = n_out;
    first_out_cyc = -1;
    drive_frame(0, 0, -1, 7560, 0, -1);
    tail_checks(16);
    drain();
    check("post_rst_count", n_out - base, 196);
    check("post_rst_latency", first_out_cyc - p22_cyc, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
